// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter and next-PC stage for the single-cycle RV32I core.
//
// Holds the PC of the instruction in execution, picks the next PC from the
// decode flags (JAL / JALR / taken branch / sequential), stalls while the
// instruction memory is not ready, and runs the RUN/HALTED/FAULT machine that
// ends simulation on a halting ECALL (x17 == 10) or on a misaligned target.
// A retired-instruction counter is kept alongside for the testbench.
//
// Ports
//   clk          in   1      core clock, rising edge
//   reset        in   1      synchronous active-high reset (wins over all)
//   is_jal       in   1      decode: JAL
//   is_jalr      in   1      decode: JALR
//   branch       in   1      decode: conditional branch
//   bcond        in   1      ALU branch condition (valid when branch=1)
//   is_ecall     in   1      decode: ECALL
//   x17_is_10    in   1      x17 == 10 (halt request)
//   imm          in   32     sign-extended immediate
//   rs1_data     in   32     rs1 read data (JALR base)
//   imem_ready   in   1      instruction memory holds a valid inst for current_pc
//   current_pc   out  32     PC of the instruction in execution
//   pc_plus4     out  32     current_pc + 4, combinational
//   retire       out  1      instruction completes this cycle, combinational
//   is_halted    out  1      registered, 1 in HALTED or FAULT
//   fault        out  1      registered, 1 only in FAULT
//   retired_cnt  out  CNT_W  retired-instruction count, wraps
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             branch,
  input  logic             bcond,
  input  logic             is_ecall,
  input  logic             x17_is_10,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             imem_ready,
  output logic [31:0]      current_pc,
  output logic [31:0]      pc_plus4,
  output logic             retire,
  output logic             is_halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      target;

  assign pc_plus4 = pc_q + 32'd4;
  assign retire   = (state_q == ST_RUN) && imem_ready;

  // Next-PC selection; decode guarantees the flags are one-hot, the if-chain
  // still encodes the priority so a decode bug cannot produce an X mix.
  always_comb begin
    if (is_jal) begin
      target = pc_q + imm;
    end else if (is_jalr) begin
      target = (rs1_data + imm) & 32'hFFFF_FFFE;
    end else if (branch && bcond) begin
      target = pc_q + imm;
    end else begin
      target = pc_plus4;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (retire) begin
      // Halting ECALL and faulting instruction still count as retired.
      cnt_d = cnt_q + CNT_W'(1);
      if (is_ecall && x17_is_10) begin
        state_d = ST_HALTED;          // PC stays on the ECALL
      end else if (target[1:0] != 2'b00) begin
        state_d = ST_FAULT;           // PC stays on the faulting instruction
      end else begin
        pc_d = target;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign current_pc  = pc_q;
  assign is_halted   = (state_q != ST_RUN);
  assign fault       = (state_q == ST_FAULT);
  assign retired_cnt = cnt_q;

endmodule
